// File: rtl/barrel_shifter_pipe_if.sv
// rtl/barrel_shifter_pipe_if.sv - operand and result stream bundle for barrel_shifter_pipe
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] in_data;
  logic [SW-1:0]    in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - log2(WIDTH)-stage pipelined barrel shifter (SLL/SRL/SRA/ROR)
module barrel_shifter_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  barrel_shifter_pipe_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  typedef logic [0:WIDTH-1] word_t;

  // Index 0 is the MSB, so the numeric shift operators match the bit movement.
  // SRA fills from data[0], which every earlier SRA step has kept equal to the original sign.
  function automatic word_t shift_step(input word_t d, input logic [1:0] mode, input int sh);
    word_t r;
    case (mode)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = word_t'($signed(d) >>> sh);
      default: r = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return r;
  endfunction

  logic [SW-1:0] vq;
  word_t         dq [SW];
  logic [SW-1:0] aq [SW];
  logic [1:0]    mq [SW];

  logic [SW-1:0] rdy;
  logic [SW-1:0] sv;
  word_t         sd [SW];
  logic [SW-1:0] sa [SW];
  logic [1:0]    sm [SW];
  word_t         nd [SW];

  // A stage can take a new beat when it is empty or its successor is taking its beat.
  always_comb begin
    logic r;
    rdy = '0;
    r   = bus.out_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      r      = !vq[k] || r;
      rdy[k] = r;
    end
  end

  always_comb begin
    sv    = '0;
    sd    = '{default: '0};
    sa    = '{default: '0};
    sm    = '{default: '0};
    nd    = '{default: '0};
    sv[0] = bus.in_valid;
    sd[0] = bus.in_data;
    sa[0] = bus.in_amt;
    sm[0] = bus.in_mode;
    for (int k = 1; k < SW; k++) begin
      sv[k] = vq[k-1];
      sd[k] = dq[k-1];
      sa[k] = aq[k-1];
      sm[k] = mq[k-1];
    end
    for (int k = 0; k < SW; k++) begin
      nd[k] = shift_step(sd[k], sm[k], sa[k][k] ? (1 << k) : 0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vq <= '0;
      for (int k = 0; k < SW; k++) begin
        dq[k] <= '0;
        aq[k] <= '0;
        mq[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (rdy[k]) begin
          vq[k] <= sv[k];
          if (sv[k]) begin
            dq[k] <= nd[k];
            aq[k] <= sa[k];
            mq[k] <= sm[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vq[SW-1];
  assign bus.out_data  = dq[SW-1];
  assign bus.out_zero  = ~|dq[SW-1];
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - self-checking bench for barrel_shifter_pipe at WIDTH=16
module tb_barrel_shifter_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  barrel_shifter_pipe_if #(.WIDTH(16)) bus ();

  barrel_shifter_pipe #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          amt;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11] = '{
    '{16'h8001, 1,  2'd0, 16'h0002},
    '{16'h8000, 1,  2'd0, 16'h0000},
    '{16'h8000, 4,  2'd2, 16'hF800},
    '{16'h8000, 4,  2'd1, 16'h0800},
    '{16'hFFFF, 15, 2'd1, 16'h0001},
    '{16'h0001, 1,  2'd3, 16'h8000},
    '{16'h1234, 8,  2'd3, 16'h3412},
    '{16'hA5A5, 0,  2'd0, 16'hA5A5},
    '{16'hA5A5, 0,  2'd1, 16'hA5A5},
    '{16'hA5A5, 0,  2'd2, 16'hA5A5},
    '{16'hA5A5, 0,  2'd3, 16'hA5A5}
  };

  // Whole-word reference: one shift of the full amount on a widened value.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int amt, input logic [1:0] m);
    logic [31:0] w;
    case (m)
      2'd0:    w = {16'h0000, d} << amt;
      2'd1:    w = {16'h0000, d} >> amt;
      2'd2:    w = 32'($signed({{16{d[15]}}, d}) >>> amt);
      default: w = {d, d} >> amt;
    endcase
    return w[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic directed(input string tag, input logic [15:0] d, input int amt,
                          input logic [1:0] m, input logic [15:0] exp);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = 4'(amt);
    bus.in_mode   = m;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    check({tag, "_zero"}, 32'(bus.out_zero), 32'(exp == 16'h0000));
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic stream(input string tag, input int n, input bit rand_ready);
    logic [15:0] q [$];
    logic [15:0] d;
    logic [15:0] exp;
    logic [1:0]  m;
    int          a;
    int          sent;
    int          recv;
    int          cyc;
    int          first;
    int          last;
    int          rdy_bad;
    int          spurious;
    bit          have;
    sent = 0; recv = 0; cyc = 0; first = -1; last = -1;
    rdy_bad = 0; spurious = 0; have = 1'b0;
    d = '0; m = '0; a = 0;
    while (recv < n && cyc < 4000) begin
      if (!have && sent < n && (!rand_ready || $urandom_range(0, 3) != 0)) begin
        d    = 16'($urandom);
        a    = $urandom_range(0, 15);
        m    = 2'($urandom);
        have = 1'b1;
      end
      bus.in_valid  = have;
      bus.in_data   = d;
      bus.in_amt    = 4'(a);
      bus.in_mode   = m;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.in_ready !== !(q.size() == 4 && !bus.out_ready)) rdy_bad++;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          spurious++;
        end else begin
          exp = q.pop_front();
          check($sformatf("%s_data%0d", tag, recv), 32'(bus.out_data), 32'(exp));
          check($sformatf("%s_zero%0d", tag, recv), 32'(bus.out_zero), 32'(exp == 16'h0000));
        end
        recv++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_shift(d, a, m));
        sent++;
        have = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_count"}, 32'(recv), 32'(n));
    check({tag, "_spurious"}, 32'(spurious), 32'd0);
    check({tag, "_ready_rule"}, 32'(rdy_bad), 32'd0);
    check({tag, "_leftover"}, 32'(q.size()), 32'd0);
    if (!rand_ready) check({tag, "_span"}, 32'(last - first), 32'(n - 1));
  endtask

  initial begin
    int acc;
    int stale;
    int guard;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_zero", 32'(bus.out_zero), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      directed($sformatf("dir%0d", i), vecs[i].d, vecs[i].amt, vecs[i].mode, vecs[i].exp);
    end

    stream("full_rate", 100, 1'b0);
    stream("rand_ready", 120, 1'b1);

    // Fill all four stages behind a stalled output, then reset mid-cycle.
    bus.out_ready = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 4 && guard < 20) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      bus.in_amt   = 4'($urandom_range(0, 15));
      bus.in_mode  = 2'($urandom);
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    check("fill_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    check("fill_out_valid", 32'(bus.out_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_out_zero", 32'(bus.out_zero), 32'd1);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    directed("post_rst", 16'h00F0, 4, 2'd0, 16'h0F00);

    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("no_stale_beats", 32'(stale), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
